mem_bank_mp: RTL and testbench

MEM_BANK_MP -- requirements
Module: mem_bank_mp

---
 rtl/mem_bank_mp_if.sv | 18 +
 rtl/mem_bank_mp.sv | 174 +++++++++++++++++
 tb/tb_mem_bank_mp.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bank_mp_if.sv
// Bank-side bus of mem_bank_mp: write port, packed read ports and sweep control/status.
interface mem_bank_mp_if #(
  parameter int W     = 24,
  parameter int ADDRW = 6,
  parameter int NRD   = 2
);
  logic                      clr_req;
  logic                      busy;
  logic                      we;
  logic                      wr_drop;
  logic [ADDRW-1:0]          waddr;
  logic [W-1:0]              wdata;
  logic [NRD-1:0][ADDRW-1:0] raddr;
  logic [NRD-1:0][W-1:0]     rdata;

  modport master (output clr_req, we, waddr, wdata, raddr, input busy, wr_drop, rdata);
  modport slave  (input clr_req, we, waddr, wdata, raddr, output busy, wr_drop, rdata);
endinterface

// File: rtl/mem_bank_mp.sv
// Multi-read-port word bank with zero-sweep clear plus two scalar registers.
// Define MEM_BANK_PARITY_EN to keep an even-parity bit per word and raise a sticky par_err.

module mem_bank_rd_lane #(
  parameter int W       = 24,
  parameter int DEPTH   = 40,
  parameter int ADDRW   = 6,
  parameter int FORWARD = 1
) (
  input  logic             busy_i,
  input  logic             we_i,
  input  logic [ADDRW-1:0] waddr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [ADDRW-1:0] raddr_i,
  input  logic [W-1:0]     rword_i,
`ifdef MEM_BANK_PARITY_EN
  input  logic             rpar_i,
  output logic             perr_o,
`endif
  output logic [W-1:0]     rdata_o
);
  localparam logic [ADDRW:0] DEPTH_X = (ADDRW+1)'(DEPTH);

  logic in_rng, fwd;
  assign in_rng = {1'b0, raddr_i} < DEPTH_X;
  assign fwd    = (FORWARD != 0) && we_i && (waddr_i == raddr_i);

  always_comb begin
    rdata_o = '0;
    if (!busy_i && in_rng) rdata_o = fwd ? wdata_i : rword_i;
  end

`ifdef MEM_BANK_PARITY_EN
  // Forwarded data never came from the array, so it cannot carry a stored-parity fault.
  assign perr_o = !busy_i && in_rng && !fwd && ((^rword_i) ^ rpar_i);
`endif
endmodule

module mem_bank_mp #(
  parameter int W       = 24,
  parameter int DEPTH   = 40,
  parameter int ADDRW   = 6,
  parameter int NRD     = 2,
  parameter int FORWARD = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_bank_mp_if.slave  bus,
  input  logic          rq_we_i,
  input  logic          rd_we_i,
  input  logic [W-1:0]  rq_d_i,
  input  logic [W-1:0]  rd_d_i,
  output logic [W-1:0]  rq_q_o,
  output logic [W-1:0]  rd_q_o,
  output logic          par_err_o
);
  typedef enum logic {SWEEP, IDLE} state_t;

  localparam logic [ADDRW:0]   DEPTH_X = (ADDRW+1)'(DEPTH);
  localparam logic [ADDRW-1:0] LAST    = ADDRW'(DEPTH-1);

  state_t           state_q, state_d;
  logic [ADDRW-1:0] sp_q, sp_d;
  logic [W-1:0]     rq_q, rd_q;
  logic             busy, wr_ok;
  logic [W-1:0]     rword [NRD];
  logic [W-1:0]     rlane [NRD];

`ifdef MEM_BANK_PARITY_EN
  logic [W:0]       mem_q [DEPTH];
  logic             par_q, par_d;
  logic [NRD-1:0]   perr;
`else
  logic [W-1:0]     mem_q [DEPTH];
`endif

  // Reset parks the FSM in SWEEP, so busy is already high while rst_n is low.
  assign busy        = (state_q == SWEEP);
  assign wr_ok       = bus.we && !busy && ({1'b0, bus.waddr} < DEPTH_X);
  assign bus.busy    = busy;
  assign bus.wr_drop = bus.we & busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    case (state_q)
      SWEEP: begin
        sp_d = sp_q + 1'b1;
        if (sp_q == LAST) state_d = IDLE;
      end
      default: begin
        if (bus.clr_req) begin
          state_d = SWEEP;
          sp_d    = '0;
        end
      end
    endcase
  end

  // Array has no reset; the sweep is the only way it gets zeroed.
  always_ff @(posedge clk) begin
    if (busy)       mem_q[sp_q]      <= '0;
`ifdef MEM_BANK_PARITY_EN
    else if (wr_ok) mem_q[bus.waddr] <= {^bus.wdata, bus.wdata};
`else
    else if (wr_ok) mem_q[bus.waddr] <= bus.wdata;
`endif
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDRW-1:0] ra;
    assign ra       = bus.raddr[k];
    assign rword[k] = ({1'b0, ra} < DEPTH_X) ? mem_q[ra][W-1:0] : '0;

    mem_bank_rd_lane #(.W(W), .DEPTH(DEPTH), .ADDRW(ADDRW), .FORWARD(FORWARD)) u_lane (
      .busy_i  (busy),
      .we_i    (bus.we),
      .waddr_i (bus.waddr),
      .wdata_i (bus.wdata),
      .raddr_i (ra),
      .rword_i (rword[k]),
`ifdef MEM_BANK_PARITY_EN
      .rpar_i  (({1'b0, ra} < DEPTH_X) ? mem_q[ra][W] : 1'b0),
      .perr_o  (perr[k]),
`endif
      .rdata_o (rlane[k])
    );
  end

  always_comb begin
    bus.rdata = '0;
    for (int k = 0; k < NRD; k++) bus.rdata[k] = rlane[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq_q <= '0;
      rd_q <= '0;
    end else begin
      if (rq_we_i) rq_q <= rq_d_i;
      if (rd_we_i) rd_q <= rd_d_i;
    end
  end

  assign rq_q_o = rq_q;
  assign rd_q_o = rd_q;

`ifdef MEM_BANK_PARITY_EN
  always_comb begin
    par_d = par_q;
    if (state_q == IDLE && bus.clr_req) par_d = 1'b0;
    else if (|perr)                     par_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign par_err_o = par_q;
`else
  assign par_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_mem_bank_mp.sv
// Directed bench for mem_bank_mp (W=24, DEPTH=8, ADDRW=3, NRD=2); a FORWARD=0 twin shares the stimulus.
module tb_mem_bank_mp;
  logic        clk, rst_n;
  logic        rq_we, rd_we;
  logic [23:0] rq_d, rd_d, rq_q, rd_q, nf_rq_q, nf_rd_q;
  logic        par_err, nf_par_err;
  int          nvec = 0;
  int          errs = 0;
  int          n;

  mem_bank_mp_if #(.W(24), .ADDRW(3), .NRD(2)) bus ();
  mem_bank_mp_if #(.W(24), .ADDRW(3), .NRD(2)) bus_nf ();

  assign bus_nf.clr_req = bus.clr_req;
  assign bus_nf.we      = bus.we;
  assign bus_nf.waddr   = bus.waddr;
  assign bus_nf.wdata   = bus.wdata;
  assign bus_nf.raddr   = bus.raddr;

  mem_bank_mp #(.W(24), .DEPTH(8), .ADDRW(3), .NRD(2), .FORWARD(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rq_we_i(rq_we), .rd_we_i(rd_we), .rq_d_i(rq_d), .rd_d_i(rd_d),
    .rq_q_o(rq_q), .rd_q_o(rd_q), .par_err_o(par_err)
  );

  mem_bank_mp #(.W(24), .DEPTH(8), .ADDRW(3), .NRD(2), .FORWARD(0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .bus(bus_nf),
    .rq_we_i(rq_we), .rd_we_i(rd_we), .rq_d_i(rq_d), .rd_d_i(rd_d),
    .rq_q_o(nf_rq_q), .rd_q_o(nf_rd_q), .par_err_o(nf_par_err)
  );

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [23:0] wd;
    logic [2:0]  ra0, ra1;
    logic [23:0] e0, e1, e0nf;
  } vec_t;
  vec_t vt [18];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time ran out before summary");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] pat(input int i);
    return {8'hA5, 8'(i), 8'h5A};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic count_busy(input string nm);
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(nm, 32'(n), 32'd8);
  endtask

  task automatic read_all_zero(input string nm);
    for (int a = 0; a < 8; a++) begin
      bus.raddr[0] = 3'(a);
      bus.raddr[1] = 3'(7 - a);
      #1;
      chk($sformatf("%s p0 a%0d", nm, a), {8'h0, bus.rdata[0]}, 32'h0);
      chk($sformatf("%s p1 a%0d", nm, 7 - a), {8'h0, bus.rdata[1]}, 32'h0);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.clr_req = 1'b0; bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.raddr = '0;
    rq_we = 1'b0; rd_we = 1'b0; rq_d = '0; rd_d = '0;
    repeat (3) tick();

    chk("rst busy", {31'h0, bus.busy}, 32'h1);
    chk("rst rq_q", {8'h0, rq_q}, 32'h0);
    chk("rst rd_q", {8'h0, rd_q}, 32'h0);
    chk("rst par_err", {31'h0, par_err}, 32'h0);
    chk("rst nf par_err", {31'h0, nf_par_err}, 32'h0);

    rst_n = 1'b1;
    count_busy("post-reset busy cycles");
    read_all_zero("post-reset");

    for (int i = 0; i < 8; i++)
      vt[i] = '{1'b1, 3'(i), pat(i), 3'(i), 3'(i), pat(i), pat(i), 24'h0};
    for (int i = 0; i < 8; i++)
      vt[8 + i] = '{1'b0, 3'd0, 24'h0, 3'(i), 3'(7 - i), pat(i), pat(7 - i), pat(i)};
    vt[16] = '{1'b1, 3'd3, 24'hDEADBE, 3'd3, 3'd4, 24'hDEADBE, 24'hA5045A, 24'hA5035A};
    vt[17] = '{1'b0, 3'd0, 24'h0,     3'd3, 3'd3, 24'hDEADBE, 24'hDEADBE, 24'hDEADBE};

    foreach (vt[i]) begin
      bus.we = vt[i].we; bus.waddr = vt[i].wa; bus.wdata = vt[i].wd;
      bus.raddr[0] = vt[i].ra0; bus.raddr[1] = vt[i].ra1;
      #1;
      chk($sformatf("vec%0d rd0", i), {8'h0, bus.rdata[0]}, {8'h0, vt[i].e0});
      chk($sformatf("vec%0d rd1", i), {8'h0, bus.rdata[1]}, {8'h0, vt[i].e1});
      chk($sformatf("vec%0d nf rd0", i), {8'h0, bus_nf.rdata[0]}, {8'h0, vt[i].e0nf});
      chk($sformatf("vec%0d wr_drop", i), {31'h0, bus.wr_drop}, 32'h0);
      tick();
    end
    bus.we = 1'b0;

    rq_we = 1'b1; rd_we = 1'b1; rq_d = 24'h001111; rd_d = 24'h223333;
    tick();
    rq_we = 1'b0; rd_we = 1'b0; rq_d = 24'h0AAAAA; rd_d = 24'h0BBBBB;
    chk("rq load", {8'h0, rq_q}, 32'h001111);
    chk("rd load", {8'h0, rd_q}, 32'h223333);
    chk("nf rq load", {8'h0, nf_rq_q}, 32'h001111);
    tick();
    chk("rq hold", {8'h0, rq_q}, 32'h001111);
    chk("rd hold", {8'h0, rd_q}, 32'h223333);

    // clear sweep: busy starts a cycle late, writes dropped, re-request ignored
    bus.raddr[0] = 3'd3; bus.raddr[1] = 3'd4;
    bus.clr_req = 1'b1;
    #1;
    chk("clr busy before edge", {31'h0, bus.busy}, 32'h0);
    tick();
    bus.clr_req = 1'b0;
    bus.we = 1'b1; bus.waddr = 3'd2; bus.wdata = 24'h123456;
    #1;
    chk("sweep wr_drop", {31'h0, bus.wr_drop}, 32'h1);
    chk("sweep rd0 masked", {8'h0, bus.rdata[0]}, 32'h0);
    chk("sweep rd1 masked", {8'h0, bus.rdata[1]}, 32'h0);
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      bus.clr_req = (n == 3);
      tick();
      n++;
    end
    bus.clr_req = 1'b0; bus.we = 1'b0;
    chk("clr sweep busy cycles", 32'(n), 32'd8);
    chk("rq after sweep", {8'h0, rq_q}, 32'h001111);
    chk("rd after sweep", {8'h0, rd_q}, 32'h223333);
    read_all_zero("post-clr");

    // reset in mid-sweep must restart the full sweep
    bus.we = 1'b1; bus.waddr = 3'd5; bus.wdata = 24'h555555;
    tick();
    bus.we = 1'b0; bus.raddr[0] = 3'd5;
    #1;
    chk("addr5 written", {8'h0, bus.rdata[0]}, 32'h555555);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("mid-sweep rst busy", {31'h0, bus.busy}, 32'h1);
    chk("mid-sweep rst rq_q", {8'h0, rq_q}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    count_busy("restart busy cycles");
    #1;
    chk("addr5 cleared", {8'h0, bus.rdata[0]}, 32'h0);

`ifdef MEM_BANK_PARITY_EN
    bus.we = 1'b1; bus.waddr = 3'd2; bus.wdata = 24'h000001;
    tick();
    bus.we = 1'b0;
    dut.mem_q[2][0] = 1'b0;
    bus.raddr[0] = 3'd2;
    #1;
    chk("par_err before edge", {31'h0, par_err}, 32'h0);
    tick();
    bus.raddr[0] = 3'd0;
    chk("par_err set", {31'h0, par_err}, 32'h1);
    tick();
    chk("par_err sticky", {31'h0, par_err}, 32'h1);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    chk("par_err cleared", {31'h0, par_err}, 32'h0);
    count_busy("parity clr sweep");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
